// File: rtl/issue_unit_pkg.sv
// Shared decode constants and the predecode record for the dual-issue stage.
// rs/rt in predec_t hold 0 when the instruction does not read that field.
package issue_pkg;

  localparam int IQ_DEPTH = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       regwrite;
    logic       load;
    logic       mem;
    logic       ctrl;
  } predec_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic logic reads(input predec_t pd, input logic [4:0] r);
    return (r != 5'd0) && ((pd.rs == r) || (pd.rt == r));
  endfunction

  function automatic logic load_use(input predec_t pd,
                                    input logic mr1, input logic [4:0] d1,
                                    input logic mr2, input logic [4:0] d2);
    return (mr1 && reads(pd, d1)) || (mr2 && reads(pd, d2));
  endfunction

endpackage

// File: rtl/issue_unit_if.sv
// Fetch-side push port, EX-side hazard inputs and the two issue slots.
// Fetch pushes on an edge where in_valid0 && in_ready; issue slots with iss_validX high are consumed by ID/EX at that same edge.
interface issue_unit_if #(parameter int PCW = 32);
  logic           in_valid0, in_valid1;
  logic [31:0]    in_instr0, in_instr1;
  logic [PCW-1:0] in_pc0, in_pc1;
  logic           in_ready;
  logic           ex_ready;
  logic           memread1_ex, memread2_ex;
  logic [4:0]     dest1_ex, dest2_ex;
  logic           iss_valid1, iss_valid2;
  logic [31:0]    iss_instr1, iss_instr2;
  logic [PCW-1:0] iss_pc1, iss_pc2;

  modport master (
    output in_valid0, in_valid1, in_instr0, in_instr1, in_pc0, in_pc1,
    output ex_ready, memread1_ex, memread2_ex, dest1_ex, dest2_ex,
    input  in_ready, iss_valid1, iss_valid2, iss_instr1, iss_instr2, iss_pc1, iss_pc2
  );

  modport slave (
    input  in_valid0, in_valid1, in_instr0, in_instr1, in_pc0, in_pc1,
    input  ex_ready, memread1_ex, memread2_ex, dest1_ex, dest2_ex,
    output in_ready, iss_valid1, iss_valid2, iss_instr1, iss_instr2, iss_pc1, iss_pc2
  );
endinterface

// File: rtl/issue_unit_predecode.sv
// Combinational MIPS predecode: source registers, destination and class flags.
module instr_predecode
  import issue_pkg::*;
(
  input  logic [31:0] instr,
  output predec_t     pd
);
  logic [5:0] op, funct;
  logic [4:0] rs_f, rt_f, rd_f;
  logic       unused_shamt;

  assign op           = instr[31:26];
  assign rs_f         = instr[25:21];
  assign rt_f         = instr[20:16];
  assign rd_f         = instr[15:11];
  assign funct        = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    pd = '0;
    case (op)
      OP_RTYPE: begin
        pd.rs = rs_f;
        if (funct == FN_JR) begin
          pd.ctrl = 1'b1;
        end else begin
          pd.rt   = rt_f;
          pd.dest = rd_f;
        end
      end
      OP_LW: begin
        pd.rs   = rs_f;
        pd.dest = rt_f;
        pd.load = 1'b1;
        pd.mem  = 1'b1;
      end
      OP_SW: begin
        pd.rs  = rs_f;
        pd.rt  = rt_f;
        pd.mem = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        pd.rs   = rs_f;
        pd.dest = rt_f;
      end
      OP_LUI: pd.dest = rt_f;
      OP_BEQ, OP_BNE: begin
        pd.rs   = rs_f;
        pd.rt   = rt_f;
        pd.ctrl = 1'b1;
      end
      OP_J:   pd.ctrl = 1'b1;
      OP_JAL: begin
        pd.ctrl = 1'b1;
        pd.dest = 5'd31;
      end
      // Unknown opcodes are treated as reading both fields so they never pair unsafely.
      default: begin
        pd.rs = rs_f;
        pd.rt = rt_f;
      end
    endcase
    pd.regwrite = (pd.dest != 5'd0);
  end
endmodule

// File: rtl/issue_unit.sv
// Dual-issue stage: circular instruction queue plus pairing and load-use rules
// deciding whether 0, 1 or 2 head entries enter EX slots 1/2 this cycle.
module issue_unit
  import issue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PCW   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  issue_unit_if.slave  bus,
  output logic [31:0]  pair_cnt,
  output logic [31:0]  stall_cnt
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]    q_instr [DEPTH];
  logic [PCW-1:0] q_pc    [DEPTH];
  logic [PW-1:0]  head, tail, head_n1, tail_n1;
  logic [CW-1:0]  count;
  predec_t        pd_a, pd_b;
  logic           a_hit, b_hit, pair_ok, dec_a, dec_b, issue_en;
  logic           v1, v2, in_rdy, unused_ld;
  logic [1:0]     push_n, pop_n;

  assign head_n1   = head + PW'(1);
  assign tail_n1   = tail + PW'(1);
  assign unused_ld = pd_a.load ^ pd_b.load;

  instr_predecode u_pd_a (.instr(q_instr[head]),    .pd(pd_a));
  instr_predecode u_pd_b (.instr(q_instr[head_n1]), .pd(pd_b));

  always_comb begin
    a_hit = load_use(pd_a, bus.memread1_ex, bus.dest1_ex, bus.memread2_ex, bus.dest2_ex);
    b_hit = load_use(pd_b, bus.memread1_ex, bus.dest1_ex, bus.memread2_ex, bus.dest2_ex);
    pair_ok = !(pd_a.regwrite && reads(pd_b, pd_a.dest))
           && !(pd_a.regwrite && pd_b.regwrite && (pd_a.dest == pd_b.dest))
           && !pd_a.ctrl && !pd_b.ctrl
           && !(pd_a.mem && pd_b.mem)
           && !b_hit;
    dec_a    = (count != '0) && !a_hit;
    dec_b    = dec_a && (count >= CW'(2)) && pair_ok;
    issue_en = bus.ex_ready && !flush && !rst;
    v1       = dec_a && issue_en;
    v2       = dec_b && issue_en;
    // Free-space test uses the pre-pop count so fetch never races a same-cycle pop.
    in_rdy   = !rst && (count <= CW'(DEPTH - 2));
    push_n   = (in_rdy && bus.in_valid0) ? (bus.in_valid1 ? 2'd2 : 2'd1) : 2'd0;
    pop_n    = {1'b0, v1} + {1'b0, v2};

    bus.in_ready   = in_rdy;
    bus.iss_valid1 = v1;
    bus.iss_valid2 = v2;
    bus.iss_instr1 = v1 ? q_instr[head]    : '0;
    bus.iss_pc1    = v1 ? q_pc[head]       : '0;
    bus.iss_instr2 = v2 ? q_instr[head_n1] : '0;
    bus.iss_pc2    = v2 ? q_pc[head_n1]    : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && (push_n != 2'd0)) begin
      q_instr[tail] <= bus.in_instr0;
      q_pc[tail]    <= bus.in_pc0;
    end
    if (!flush && (push_n == 2'd2)) begin
      q_instr[tail_n1] <= bus.in_instr1;
      q_pc[tail_n1]    <= bus.in_pc1;
    end
  end

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (v2) pair_cnt <= pair_cnt + 32'd1;
      if ((count != '0) && bus.ex_ready && !v1 && !flush) stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: directed pairing scenarios, then random traffic checked
// against a queue-based reference model using register read masks.
module tb_issue_unit;
  localparam int DEPTH = 4;
  localparam int PCW   = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] pair_cnt, stall_cnt;

  issue_unit_if #(.PCW(PCW)) bus ();

  issue_unit #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .pair_cnt(pair_cnt), .stall_cnt(stall_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: {pc, instr} in program order
  logic [63:0] exp_q[$];
  logic [31:0] m_pair, m_stall, pc_ctr, s0;
  int unsigned n_checks, n_pass;
  logic        obs_v1, obs_v2, obs_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a, b, c;
    logic [15:0] imm;
    logic [25:0] tgt;
    a = rreg(); b = rreg(); c = rreg();
    imm = 16'($urandom);
    tgt = 26'($urandom);
    case ($urandom_range(0, 12))
      0:  return rtype(c, a, b, 6'h20);
      1:  return rtype(c, a, b, 6'h22);
      2:  return rtype(5'd0, a, 5'd0, 6'h08);
      3:  return itype(6'h23, a, b, imm);
      4:  return itype(6'h2b, a, b, imm);
      5:  return itype(6'h08, a, b, imm);
      6:  return itype(6'h0d, a, b, imm);
      7:  return itype(6'h0a, a, b, imm);
      8:  return itype(6'h0f, a, b, imm);
      9:  return itype(6'h04, a, b, imm);
      10: return itype(6'h05, a, b, imm);
      11: return {6'h02, tgt};
      default: return {6'h03, tgt};
    endcase
  endfunction

  // Reference decode: set of registers read (bit mask), register written, class.
  function automatic void mdec(input logic [31:0] ins, output logic [31:0] srcs,
                               output logic [4:0] dst, output bit is_mem, output bit is_ctl);
    logic [4:0] rs, rt, rd;
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    srcs = '0; dst = '0; is_mem = 0; is_ctl = 0;
    case (ins[31:26])
      6'h00: if (ins[5:0] == 6'h08) begin srcs[rs] = 1'b1; is_ctl = 1; end
             else begin srcs[rs] = 1'b1; srcs[rt] = 1'b1; dst = rd; end
      6'h23: begin srcs[rs] = 1'b1; dst = rt; is_mem = 1; end
      6'h2b: begin srcs[rs] = 1'b1; srcs[rt] = 1'b1; is_mem = 1; end
      6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e: begin srcs[rs] = 1'b1; dst = rt; end
      6'h0f: dst = rt;
      6'h04, 6'h05: begin srcs[rs] = 1'b1; srcs[rt] = 1'b1; is_ctl = 1; end
      6'h02: is_ctl = 1;
      6'h03: begin is_ctl = 1; dst = 5'd31; end
      default: begin srcs[rs] = 1'b1; srcs[rt] = 1'b1; end
    endcase
    srcs[0] = 1'b0;
  endfunction

  function automatic int exp_issue();
    logic [31:0] sa, sb, ldm;
    logic [4:0]  da, db;
    bit          ma, ca, mb, cb;
    int          n;
    n = 0;
    ldm = '0;
    if (bus.memread1_ex) ldm[bus.dest1_ex] = 1'b1;
    if (bus.memread2_ex) ldm[bus.dest2_ex] = 1'b1;
    ldm[0] = 1'b0;
    if (!rst && exp_q.size() >= 1) begin
      mdec(exp_q[0][31:0], sa, da, ma, ca);
      if ((sa & ldm) == '0) begin
        n = 1;
        if (exp_q.size() >= 2) begin
          mdec(exp_q[1][31:0], sb, db, mb, cb);
          if (!(da != 0 && sb[da]) && !(da != 0 && da == db) && !ca && !cb
              && !(ma && mb) && ((sb & ldm) == '0))
            n = 2;
        end
      end
    end
    if (!bus.ex_ready || flush) n = 0;
    return n;
  endfunction

  task automatic offer(input logic [31:0] i0, input logic [31:0] i1, input int nv);
    bus.in_valid0 = (nv >= 1);
    bus.in_valid1 = (nv >= 2);
    bus.in_instr0 = i0;
    bus.in_instr1 = i1;
    bus.in_pc0    = pc_ctr;
    bus.in_pc1    = pc_ctr + 32'd4;
  endtask

  // One cycle: sample at negedge, compare with model, advance model across the edge.
  task automatic step();
    int          n, sz;
    bit          rdy;
    logic [63:0] a, b;
    @(negedge clk);
    sz  = exp_q.size();
    rdy = !rst && ((DEPTH - sz) >= 2);
    n   = exp_issue();
    a = '0; b = '0;
    if (n >= 1) a = exp_q[0];
    if (n == 2) b = exp_q[1];
    obs_v1 = bus.iss_valid1; obs_v2 = bus.iss_valid2; obs_rdy = bus.in_ready;
    check("in_ready", bus.in_ready, rdy);
    check("iss_valid1", bus.iss_valid1, (n >= 1));
    check("iss_valid2", bus.iss_valid2, (n == 2));
    check("slot1_pc_instr", {bus.iss_pc1, bus.iss_instr1}, a);
    check("slot2_pc_instr", {bus.iss_pc2, bus.iss_instr2}, b);
    check("pair_cnt", pair_cnt, m_pair);
    check("stall_cnt", stall_cnt, m_stall);
    if (rst) begin
      exp_q.delete(); m_pair = '0; m_stall = '0;
    end else begin
      if (n == 2) m_pair++;
      if (sz > 0 && bus.ex_ready && n == 0 && !flush) m_stall++;
      if (flush) exp_q.delete();
      else begin
        repeat (n) void'(exp_q.pop_front());
        if (rdy && bus.in_valid0) begin
          exp_q.push_back({bus.in_pc0, bus.in_instr0});
          pc_ctr += 32'd4;
          if (bus.in_valid1) begin
            exp_q.push_back({bus.in_pc1, bus.in_instr1});
            pc_ctr += 32'd4;
          end
        end
      end
    end
    @(posedge clk); #1;
    bus.in_valid0 = 1'b0;
    bus.in_valid1 = 1'b0;
    flush = 1'b0;
  endtask

  logic [31:0] pa[3], pb[3];

  initial begin
    n_checks = 0; n_pass = 0; m_pair = '0; m_stall = '0; pc_ctr = 32'h0000_1000;
    bus.in_valid0 = 0; bus.in_valid1 = 0; bus.in_instr0 = '0; bus.in_instr1 = '0;
    bus.in_pc0 = '0; bus.in_pc1 = '0; bus.ex_ready = 1;
    bus.memread1_ex = 0; bus.memread2_ex = 0; bus.dest1_ex = '0; bus.dest2_ex = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step();
    check("reset_ready_low", obs_rdy, 1'b0);
    rst = 1'b0;
    step();
    check("post_reset_ready", obs_rdy, 1'b1);

    // two independent adds dual-issue
    offer(rtype(3, 1, 2, 6'h20), rtype(6, 4, 5, 6'h20), 2); step();
    step();
    check("dual_issue", {obs_v1, obs_v2}, 2'b11);
    check("dual_pair_cnt", pair_cnt, 32'd1);

    // RAW inside the pair
    offer(rtype(3, 1, 2, 6'h20), rtype(4, 3, 1, 6'h22), 2); step();
    step(); check("raw_first", {obs_v1, obs_v2}, 2'b10);
    step(); check("raw_second", {obs_v1, obs_v2}, 2'b10);

    // load-use against EX slot 1
    bus.memread1_ex = 1; bus.dest1_ex = 5'd8;
    offer(itype(6'h23, 8, 9, 16'h0), rtype(10, 8, 1, 6'h20), 2); step();
    s0 = stall_cnt;
    step();
    check("load_use_block", obs_v1, 1'b0);
    check("load_use_stall", stall_cnt, s0 + 32'd1);
    bus.memread1_ex = 0;
    step(); check("load_use_clear", obs_v1, 1'b1);

    // control / memory / jal pairs issue singly
    pa[0] = itype(6'h04, 1, 2, 16'h4);  pb[0] = rtype(7, 1, 2, 6'h20);
    pa[1] = itype(6'h23, 1, 5, 16'h0);  pb[1] = itype(6'h2b, 2, 6, 16'h4);
    pa[2] = {6'h03, 26'h100};           pb[2] = itype(6'h08, 1, 31, 16'h1);
    for (int k = 0; k < 3; k++) begin
      offer(pa[k], pb[k], 2); step();
      step(); check("single_first", {obs_v1, obs_v2}, 2'b10);
      step(); check("single_second", {obs_v1, obs_v2}, 2'b10);
    end

    // fill to DEPTH while stalled, then drain across the pointer wrap
    bus.ex_ready = 0;
    offer(rtype(11, 1, 2, 6'h20), rtype(12, 1, 2, 6'h20), 2); step();
    offer(rtype(13, 1, 2, 6'h20), rtype(14, 1, 2, 6'h20), 2); step();
    step(); check("full_not_ready", obs_rdy, 1'b0);
    bus.ex_ready = 1;
    repeat (3) step();

    // flush with three entries and a simultaneous push
    bus.ex_ready = 0;
    offer(rtype(3, 1, 2, 6'h20), rtype(6, 4, 5, 6'h20), 2); step();
    offer(rtype(7, 1, 2, 6'h20), 32'h0, 1); step();
    flush = 1;
    offer(rtype(8, 1, 2, 6'h20), rtype(9, 1, 2, 6'h20), 2); step();
    bus.ex_ready = 1;
    step();
    check("flush_empty", obs_v1, 1'b0);
    check("flush_ready", obs_rdy, 1'b1);

    // downstream stall holds entries without counting stalls
    bus.ex_ready = 0;
    offer(rtype(3, 1, 2, 6'h20), rtype(6, 4, 5, 6'h20), 2); step();
    s0 = stall_cnt;
    repeat (3) step();
    check("hold_no_issue", obs_v1, 1'b0);
    check("hold_stall_cnt", stall_cnt, s0);
    bus.ex_ready = 1;
    step(); check("hold_release", {obs_v1, obs_v2}, 2'b11);

    // random traffic with a mid-run reset
    for (int i = 0; i < 1500; i++) begin
      rst = (i == 700 || i == 701);
      offer(rand_instr(), rand_instr(), 0);
      bus.in_valid0   = ($urandom_range(0, 3) != 0);
      bus.in_valid1   = ($urandom_range(0, 1) == 1);
      bus.ex_ready    = ($urandom_range(0, 4) != 0);
      flush           = ($urandom_range(0, 24) == 0);
      bus.memread1_ex = ($urandom_range(0, 2) == 0);
      bus.memread2_ex = ($urandom_range(0, 2) == 0);
      bus.dest1_ex    = rreg();
      bus.dest2_ex    = rreg();
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/issue_unit.md
# issue_unit

Dual-issue instruction issue stage for the MIPS pipeline, in ID just upstream of the ID/EX register and the forwarding unit. Buffers fetched instructions in a small circular queue and decides each cycle whether to issue two, one or zero instructions into EX slots 1/2. It enforces the pairing rules the forwarding unit cannot cover: intra-pair dependencies, control and memory pairing, and load-use bubbles against EX-stage loads.

## Interface
- DEPTH, 4, queue entries; power of 2, ≥ 4
- PCW, 32, PC width
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid0 / in_valid1  in  1  fetch slot valid; in_valid1 counts only with in_valid0
- in_instr0 / in_instr1  in  32  fetched instructions; slot 0 is older
- in_pc0 / in_pc1  in  PCW  matching PCs
- in_ready  out  1  free entries ≥ 2; fetch pushes only when high
- flush  in  1  branch mispredict/redirect; empties queue
- ex_ready  in  1  ID/EX may advance; low = downstream stall
- memread1_ex / memread2_ex  in  1  EX slot 1/2 holds a load
- dest1_ex / dest2_ex  in  5  EX slot 1/2 destination register
- iss_valid1 / iss_valid2  out  1  issue slot 1/2 valid this cycle
- iss_instr1 / iss_instr2  out  32  issued instructions
- iss_pc1 / iss_pc2  out  PCW  issued PCs
- pair_cnt  out  32  cycles with dual issue
- stall_cnt  out  32  cycles with a non-empty queue and zero issue

## Operation
- Predecode per entry: rs=[25:21], rt=[20:16]. R-type (op 0): dest rd, regwrite unless funct 0x08 (jr). lw 0x23: dest rt, load. sw 0x2b: reads rs,rt, no write. addi/slti/andi/ori/xori/lui: dest rt. beq/bne 0x04/0x05: control, read rs,rt. j 0x02: control. jal 0x03: control, dest 31. jr: control. Dest 0 means no write.
- A = head entry; B = head+1, valid only when count ≥ 2.
- Load-use on A: A reads a register equal to a nonzero destX_ex with memreadX_ex → issue 0.
- Otherwise issue A. Also issue B unless any of these holds:
- B reads A's dest.
- B dest == A dest (both nonzero).
- A or B is control.
- A and B both memory ops.
- B has a load-use hit.
- Slot order is fixed: A → slot 1, B → slot 2. iss_valid2 implies iss_valid1.
- iss_validX = decision & ex_ready & ~flush. Pop count equals the number of asserted valids.
- Push: n = in_valid0 + (in_valid0 & in_valid1) when in_ready. Otherwise the push is dropped; fetch must hold.
- Pointers wrap modulo DEPTH. Count is updated as count + push − pop, in the same cycle.
- in_ready is computed from pre-pop count (conservative) and is forced 0 while rst is high.
- flush: next cycle count=0 and pointers=0. Same-cycle push and pop are discarded. Counters are not reset.
- Counters: 32-bit, wrap on overflow. pair_cnt increments when iss_valid2. stall_cnt increments when count>0 & ex_ready & ~iss_valid1 & ~flush.

## Timing
- Reset: count, pointers, pair_cnt, stall_cnt = 0. All iss_* outputs are 0; in_ready is 0 during reset and 1 on the first cycle after.
- Push-to-issue latency is 1 cycle: an entry written at edge N can issue in cycle N+1.
- iss_* outputs are combinational from queue head and the EX inputs, and are consumed at the next edge.
- While ex_ready is low, the queue holds and iss_valid is 0. Push is still accepted while free ≥ 2.
- Reset or flush asserted mid-burst takes priority over push and pop in that cycle.

## Structure
- Package issue_pkg holds opcode/funct constants, predecode struct {rs, rt, dest, regwrite, load, mem, ctrl} and the DEPTH-derived pointer width.
- Sub-module instr_predecode (combinational) is instantiated twice, for A and B. Queue storage and control live in issue_unit.

## Test plan
- Reset, then push add $3,$1,$2 and add $6,$4,$5 with ex_ready=1 → next cycle iss_valid1=iss_valid2=1 and pair_cnt=1.
- Push add $3,$1,$2 then sub $4,$3,$1 → first cycle only slot 1 issues; sub issues alone next cycle.
- memread1_ex=1, dest1_ex=8, head lw/add reading $8 → iss_valid1=0 and stall_cnt increments; after EX clears, head issues.
- Pushes: beq and add, lw and sw, jal and addi $31 → each pair issues singly in order. Fill to DEPTH → in_ready=0; pointer wrap keeps PC order.
- flush asserted with 3 entries queued and a simultaneous push → next cycle queue empty, iss_valid=0, in_ready=1.
- ex_ready=0 for 3 cycles with 2 entries queued → no issue, stall_cnt unchanged, entries retained and issued once ex_ready=1.
